cam_reg_write_sequencer: RTL and testbench
==========================================

Name: cam_reg_write_sequencer

Overview:
- Parametrised successor to the camera register write path: accepts high-level camera commands (exposure, crop, config/binning) for any of NUM_CAMS sensors.
- Queues commands in a FIFO and expands each into a list of 16-bit sensor register writes.
- Streams those writes as bytes (addr, MSB, LSB) to the cam I2C interface over a valid/ready handshake.
- Sits between the instruction buffer and the per-camera I2C/cam interface logic; also holds per-camera compression/RGB config.

Parameters:
- NUM_CAMS, 2, number of camera channels.
- CAM_W, 1, width of camera index; must be >= 1 and 2**CAM_W >= NUM_CAMS.
- FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2.

Ports:
- sysClk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_addr  in  8  command code.
- cmd_data  in  64  command payload.
- cmd_cam  in  CAM_W  target camera index.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- i2c_byte  out  8  byte to cam I2C interface.
- i2c_valid  out  1  i2c_byte valid.
- i2c_ready  in  1  cam I2C interface accepts byte.
- i2c_first  out  1  current byte is a register-address byte (start of a 3-byte write).
- i2c_cam  out  CAM_W  camera the current byte targets.
- cmd_done  out  1  1-cycle pulse after the last byte of a command is accepted.
- cmd_err  out  1  1-cycle pulse when a popped command is rejected.
- compression  out  2*NUM_CAMS  per-camera compression, 2 bits per camera.
- rgb  out  NUM_CAMS  per-camera RGB enable.

Behaviour:
- Reset: FIFO empty, FSM to IDLE, i2c_valid=0, i2c_byte=0, i2c_first=0, i2c_cam=0, cmd_done=0, cmd_err=0, compression=0, rgb=0. cmd_ready=1 the cycle after reset deasserts.
- Reset mid-command: the command is abandoned with no done/err pulse; queued commands are discarded.
- Push occurs when cmd_valid && cmd_ready. cmd_ready = !full, with no bypass; a push offered while full is not taken.
- Pop happens only in IDLE with FIFO non-empty. Push and pop in the same cycle are legal.
- Latency: command accepted at edge N; the first byte is valid after edge N+2 when the FSM is idle.
- FSM states and transitions:
  - IDLE: pop a command → DECODE.
  - DECODE: classify the command, set write index k=0. Valid class → ADDR. Invalid command → ERR.
  - ERR: pulse cmd_err → IDLE.
  - ADDR → MSB → LSB: one byte each. Advance only on i2c_valid && i2c_ready. i2c_byte, i2c_first and i2c_cam are held stable while valid && !ready.
  - After LSB is accepted: if k is the last write of the class → DONE, else k++ → ADDR.
  - DONE: pulse cmd_done → IDLE.
- i2c_valid is deasserted between commands. Back-to-back bytes within a command add no bubble.
- Command expansion (value is 16 bits; zero-extend narrower fields):
  - 0x00/0x01 CONFIG:
    - Latch compression[cam]=data[1:0] and rgb[cam]=data[2] in DECODE.
    - Writes 0x22 = {10'd0, data[4:3], 4'd0} (row bin), then 0x23 = {10'd0, data[6:5], 4'd0} (column bin).
  - 0x02/0x03 EXPOSURE: writes 0x08 = data[22:19], then 0x09 = data[18:3], then 0x0C = data[35:23].
  - 0x05/0x06 CROP: writes 0x01 = data[63:48], 0x02 = data[47:32], 0x03 = data[31:16], 0x04 = data[15:0].
  - Any other code, or cmd_cam >= NUM_CAMS → ERR. Config registers are unchanged and no bytes are emitted.
- k is 2 bits wide, since the longest class has 4 writes. The FIFO pointers carry 1 extra wrap bit for full/empty.

Decomposition:
- Package cam_cmd_pkg holds:
  - command codes (CMD_CONFIG_A/B, CMD_EXPO_A/B, CMD_CROP_A/B);
  - sensor register addresses (REG_ROW_START 0x01, REG_COL_START 0x02, REG_ROW_SIZE 0x03, REG_COL_SIZE 0x04, REG_SHUT_UP 0x08, REG_SHUT_LO 0x09, REG_SHUT_DLY 0x0C, REG_ROW_MODE 0x22, REG_COL_MODE 0x23);
  - the class enum (CLS_CONFIG, CLS_EXPO, CLS_CROP, CLS_BAD);
  - the FSM state enum.
- Sub-module cam_cmd_expander is combinational. Inputs: class, data, k. Outputs: reg_addr[7:0], reg_val[15:0], last.
- The FIFO is inline.

Test Plan:
- EXPOSURE: cmd_addr=0x02, cam=1, data[22:19]=0xA, data[18:3]=0x1234, data[35:23]=0x0055, i2c_ready=1 → bytes 08 00 0A 09 12 34 0C 00 55; i2c_first set on 08/09/0C; i2c_cam=1; cmd_done pulses once.
- CROP with backpressure: cmd_addr=0x05, data=0x0010_0020_0300_0400, i2c_ready toggling 1/0 → bytes 01 00 10 02 00 20 03 03 00 04 04 00 with no byte dropped or repeated while held.
- CONFIG: cmd_addr=0x00, cam=0, data=0x7F → compression[1:0]=3, rgb[0]=1, bytes 22 00 30 23 00 30, camera 1 config unchanged.
- Error: cmd_addr=0x07, and separately cam=NUM_CAMS → one cmd_err pulse each, no i2c_valid, no cmd_done.
- FIFO: with i2c_ready=0, push 4 commands → cmd_ready=0 after the 4th; the 5th is not accepted. Then release i2c_ready → the 4 commands complete in order.
- Reset asserted during the MSB byte of an EXPOSURE command → the next cycle i2c_valid=0 and the FIFO is empty; a new command afterward runs correctly from its ADDR byte.

Source files
------------

// File: rtl/cam_cmd_pkg.sv
// Shared command codes, sensor register map, command classes and sequencer
// states for the camera register write path.
package cam_cmd_pkg;

  localparam logic [7:0] CMD_CONFIG_A = 8'h00;
  localparam logic [7:0] CMD_CONFIG_B = 8'h01;
  localparam logic [7:0] CMD_EXPO_A   = 8'h02;
  localparam logic [7:0] CMD_EXPO_B   = 8'h03;
  localparam logic [7:0] CMD_CROP_A   = 8'h05;
  localparam logic [7:0] CMD_CROP_B   = 8'h06;

  localparam logic [7:0] REG_ROW_START = 8'h01;
  localparam logic [7:0] REG_COL_START = 8'h02;
  localparam logic [7:0] REG_ROW_SIZE  = 8'h03;
  localparam logic [7:0] REG_COL_SIZE  = 8'h04;
  localparam logic [7:0] REG_SHUT_UP   = 8'h08;
  localparam logic [7:0] REG_SHUT_LO   = 8'h09;
  localparam logic [7:0] REG_SHUT_DLY  = 8'h0C;
  localparam logic [7:0] REG_ROW_MODE  = 8'h22;
  localparam logic [7:0] REG_COL_MODE  = 8'h23;

  typedef enum logic [1:0] {
    CLS_CONFIG = 2'd0,
    CLS_EXPO   = 2'd1,
    CLS_CROP   = 2'd2,
    CLS_BAD    = 2'd3
  } cls_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_ADDR   = 3'd2,
    ST_MSB    = 3'd3,
    ST_LSB    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  // An out-of-range camera index makes any command invalid.
  function automatic cls_e classify(input logic [7:0] code, input logic cam_ok);
    cls_e c;
    case (code)
      CMD_CONFIG_A, CMD_CONFIG_B: c = CLS_CONFIG;
      CMD_EXPO_A,   CMD_EXPO_B:   c = CLS_EXPO;
      CMD_CROP_A,   CMD_CROP_B:   c = CLS_CROP;
      default:                    c = CLS_BAD;
    endcase
    return cam_ok ? c : CLS_BAD;
  endfunction

endpackage

// File: rtl/cam_reg_write_sequencer_if.sv
// Command-side and I2C-side bus of the camera register write sequencer.
interface cam_reg_write_sequencer_if #(
  parameter int NUM_CAMS = 2,
  parameter int CAM_W    = 1
);
  import cam_cmd_pkg::*;

  logic [7:0]            cmd_addr;
  logic [63:0]           cmd_data;
  logic [CAM_W-1:0]      cmd_cam;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [7:0]            i2c_byte;
  logic                  i2c_valid;
  logic                  i2c_ready;
  logic                  i2c_first;
  logic [CAM_W-1:0]      i2c_cam;
  logic                  cmd_done;
  logic                  cmd_err;
  logic [2*NUM_CAMS-1:0] compression;
  logic [NUM_CAMS-1:0]   rgb;

  modport slave (
    input  cmd_addr, cmd_data, cmd_cam, cmd_valid, i2c_ready,
    output cmd_ready, i2c_byte, i2c_valid, i2c_first, i2c_cam,
    output cmd_done, cmd_err, compression, rgb
  );

  modport master (
    output cmd_addr, cmd_data, cmd_cam, cmd_valid, i2c_ready,
    input  cmd_ready, i2c_byte, i2c_valid, i2c_first, i2c_cam,
    input  cmd_done, cmd_err, compression, rgb
  );

endinterface

// File: rtl/cam_cmd_expander.sv
// Maps (command class, payload, write index) to one 16-bit sensor register
// write and flags the final write of the class.
module cam_cmd_expander
  import cam_cmd_pkg::*;
(
  input  cls_e        cls,
  input  logic [63:0] data,
  input  logic [1:0]  k,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_val,
  output logic        last
);

  // Register list per class, indexed by k
  always_comb begin
    reg_addr = 8'h00;
    reg_val  = 16'h0000;
    last     = 1'b1;
    case (cls)
      CLS_CONFIG: begin
        last = (k == 2'd1);
        if (k == 2'd0) begin
          reg_addr = REG_ROW_MODE;
          reg_val  = {10'd0, data[4:3], 4'd0};
        end else begin
          reg_addr = REG_COL_MODE;
          reg_val  = {10'd0, data[6:5], 4'd0};
        end
      end
      CLS_EXPO: begin
        last = (k == 2'd2);
        case (k)
          2'd0: begin reg_addr = REG_SHUT_UP;  reg_val = {12'd0, data[22:19]}; end
          2'd1: begin reg_addr = REG_SHUT_LO;  reg_val = data[18:3];           end
          default: begin reg_addr = REG_SHUT_DLY; reg_val = {3'd0, data[35:23]}; end
        endcase
      end
      CLS_CROP: begin
        last = (k == 2'd3);
        case (k)
          2'd0:    begin reg_addr = REG_ROW_START; reg_val = data[63:48]; end
          2'd1:    begin reg_addr = REG_COL_START; reg_val = data[47:32]; end
          2'd2:    begin reg_addr = REG_ROW_SIZE;  reg_val = data[31:16]; end
          default: begin reg_addr = REG_COL_SIZE;  reg_val = data[15:0];  end
        endcase
      end
      default: begin
        reg_addr = 8'h00;
        reg_val  = 16'h0000;
        last     = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cam_reg_write_sequencer.sv
// Queues camera commands and streams their sensor register writes as
// addr/MSB/LSB bytes; also holds per-camera compression/RGB config.
module cam_reg_write_sequencer
  import cam_cmd_pkg::*;
#(
  parameter int NUM_CAMS   = 2,
  parameter int CAM_W      = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic sysClk,
  input logic rst,
  cam_reg_write_sequencer_if.slave bus
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PTR_W = AW + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [7:0]       fifo_addr [FIFO_DEPTH];
  logic [63:0]      fifo_data [FIFO_DEPTH];
  logic [CAM_W-1:0] fifo_cam  [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, empty, push, pop;
  logic [CAM_W-1:0] head_cam;
  logic             head_cam_ok;

  state_e           state, state_nxt;
  cls_e             cls_q;
  logic [63:0]      data_q;
  logic [CAM_W-1:0] cam_q;
  logic [1:0]       k, k_nxt, k_sel;
  logic             last_q, last_nxt;
  logic [7:0]       byte_q, byte_nxt;
  logic             first_q, first_nxt;
  logic             valid_q, valid_nxt;
  logic             done_q, done_nxt;
  logic             err_q, err_nxt;
  logic             accept;
  logic [2*NUM_CAMS-1:0] comp_q;
  logic [NUM_CAMS-1:0]   rgb_q;

  logic [7:0]  exp_addr;
  logic [15:0] exp_val;
  logic        exp_last;

  // The extra pointer bit separates full from empty when the indices match.
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push        = bus.cmd_valid && !full;
  assign head_cam    = fifo_cam[rd_ptr[AW-1:0]];
  assign head_cam_ok = (32'(head_cam) < 32'(NUM_CAMS));
  assign accept      = valid_q && bus.i2c_ready;

  // Once LSB is on the bus only the next write's address is needed.
  assign k_sel = (state == ST_LSB) ? (k + 2'd1) : k;

  cam_cmd_expander u_expander (
    .cls      (cls_q),
    .data     (data_q),
    .k        (k_sel),
    .reg_addr (exp_addr),
    .reg_val  (exp_val),
    .last     (exp_last)
  );

  // Command FIFO storage
  always_ff @(posedge sysClk) begin
    if (push) begin
      fifo_addr[wr_ptr[AW-1:0]] <= bus.cmd_addr;
      fifo_data[wr_ptr[AW-1:0]] <= bus.cmd_data;
      fifo_cam[wr_ptr[AW-1:0]]  <= bus.cmd_cam;
    end
  end

  // Command FIFO pointers
  always_ff @(posedge sysClk) begin
    if (rst) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // FSM state register
  always_ff @(posedge sysClk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state and next values of the registered outputs
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    last_nxt  = last_q;
    byte_nxt  = byte_q;
    first_nxt = first_q;
    valid_nxt = valid_q;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          k_nxt     = 2'd0;
          state_nxt = ST_DECODE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (cls_q == CLS_BAD) begin
          err_nxt   = 1'b1;
          state_nxt = ST_ERR;
        end else begin
          valid_nxt = 1'b1;
          first_nxt = 1'b1;
          byte_nxt  = exp_addr;
          state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (accept) begin
          byte_nxt  = exp_val[15:8];
          first_nxt = 1'b0;
          last_nxt  = exp_last;
          state_nxt = ST_MSB;
        end else begin
          state_nxt = ST_ADDR;
        end
      end
      ST_MSB: begin
        if (accept) begin
          byte_nxt  = exp_val[7:0];
          state_nxt = ST_LSB;
        end else begin
          state_nxt = ST_MSB;
        end
      end
      ST_LSB: begin
        if (accept && last_q) begin
          valid_nxt = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = ST_DONE;
        end else if (accept) begin
          k_nxt     = k + 2'd1;
          byte_nxt  = exp_addr;
          first_nxt = 1'b1;
          state_nxt = ST_ADDR;
        end else begin
          state_nxt = ST_LSB;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_IDLE;
      default: begin
        valid_nxt = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Popped command, write index, output registers and camera config
  always_ff @(posedge sysClk) begin
    if (rst) begin
      cls_q   <= CLS_BAD;
      data_q  <= 64'd0;
      cam_q   <= {CAM_W{1'b0}};
      k       <= 2'd0;
      last_q  <= 1'b0;
      byte_q  <= 8'd0;
      first_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      comp_q  <= {(2*NUM_CAMS){1'b0}};
      rgb_q   <= {NUM_CAMS{1'b0}};
    end else begin
      if (pop) begin
        cls_q  <= classify(fifo_addr[rd_ptr[AW-1:0]], head_cam_ok);
        data_q <= fifo_data[rd_ptr[AW-1:0]];
        cam_q  <= head_cam;
      end
      k       <= k_nxt;
      last_q  <= last_nxt;
      byte_q  <= byte_nxt;
      first_q <= first_nxt;
      valid_q <= valid_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      for (int i = 0; i < NUM_CAMS; i++) begin
        if (state == ST_DECODE && cls_q == CLS_CONFIG && cam_q == CAM_W'(i)) begin
          comp_q[2*i +: 2] <= data_q[1:0];
          rgb_q[i]         <= data_q[2];
        end
      end
    end
  end

  assign bus.cmd_ready   = !full;
  assign bus.i2c_byte    = byte_q;
  assign bus.i2c_valid   = valid_q;
  assign bus.i2c_first   = first_q;
  assign bus.i2c_cam     = cam_q;
  assign bus.cmd_done    = done_q;
  assign bus.cmd_err     = err_q;
  assign bus.compression = comp_q;
  assign bus.rgb         = rgb_q;

endmodule

// File: tb/tb_cam_reg_write_sequencer.sv
// Scoreboard bench for cam_reg_write_sequencer: expected bytes and command
// outcomes are queued as commands are driven and matched as the DUT emits them.
module tb_cam_reg_write_sequencer;

  localparam int NC = 3;
  localparam int CW = 2;

  logic sysClk = 1'b0;
  logic rst    = 1'b1;
  always #5 sysClk = ~sysClk;

  cam_reg_write_sequencer_if #(.NUM_CAMS(NC), .CAM_W(CW)) bus ();

  cam_reg_write_sequencer #(.NUM_CAMS(NC), .CAM_W(CW), .FIFO_DEPTH(4)) dut (
    .sysClk (sysClk),
    .rst    (rst),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [10:0] exp_bytes [$];   // {first, cam, byte}
  bit          exp_out   [$];   // 1 = error, 0 = done
  logic [2*NC-1:0] mdl_comp;
  logic [NC-1:0]   mdl_rgb;
  int rdy_mode = 0;             // 0 always, 1 toggle, 2 held low, 3 random

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic void push_wr(input logic [7:0] ra, input logic [15:0] v, input logic [1:0] c);
    exp_bytes.push_back({1'b1, c, ra});
    exp_bytes.push_back({1'b0, c, v[15:8]});
    exp_bytes.push_back({1'b0, c, v[7:0]});
  endfunction

  function automatic void model_cmd(input logic [7:0] a, input logic [63:0] d, input logic [1:0] c);
    if (c >= NC) begin
      exp_out.push_back(1'b1);
      return;
    end
    case (a)
      8'h00, 8'h01: begin
        mdl_comp[2*c +: 2] = d[1:0];
        mdl_rgb[c]         = d[2];
        push_wr(8'h22, {10'd0, d[4:3], 4'd0}, c);
        push_wr(8'h23, {10'd0, d[6:5], 4'd0}, c);
        exp_out.push_back(1'b0);
      end
      8'h02, 8'h03: begin
        push_wr(8'h08, {12'd0, d[22:19]}, c);
        push_wr(8'h09, d[18:3], c);
        push_wr(8'h0C, {3'd0, d[35:23]}, c);
        exp_out.push_back(1'b0);
      end
      8'h05, 8'h06: begin
        push_wr(8'h01, d[63:48], c);
        push_wr(8'h02, d[47:32], c);
        push_wr(8'h03, d[31:16], c);
        push_wr(8'h04, d[15:0], c);
        exp_out.push_back(1'b0);
      end
      default: exp_out.push_back(1'b1);
    endcase
  endfunction

  // i2c_ready driver, updated 2 time units after each rising edge
  initial begin
    bus.i2c_ready = 1'b0;
    forever begin
      @(posedge sysClk);
      #2;
      case (rdy_mode)
        0:       bus.i2c_ready = 1'b1;
        1:       bus.i2c_ready = ~bus.i2c_ready;
        2:       bus.i2c_ready = 1'b0;
        default: bus.i2c_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor on the falling edge
  initial begin
    logic        hold_pend;
    logic [10:0] hold_val;
    logic [10:0] obs;
    hold_pend = 1'b0;
    hold_val  = 11'd0;
    forever begin
      @(negedge sysClk);
      obs = {bus.i2c_first, bus.i2c_cam, bus.i2c_byte};
      if (rst) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          check_eq("hold_valid", 64'(bus.i2c_valid), 64'd1);
          check_eq("hold_byte", 64'(obs), 64'(hold_val));
        end
        hold_pend = bus.i2c_valid && !bus.i2c_ready;
        hold_val  = obs;
        if (bus.i2c_valid && bus.i2c_ready) begin
          check_eq("byte_expected", 64'(exp_bytes.size() != 0), 64'd1);
          if (exp_bytes.size() != 0) check_eq("i2c_byte", 64'(obs), 64'(exp_bytes.pop_front()));
        end
        if (bus.cmd_done || bus.cmd_err) begin
          check_eq("outcome_expected", 64'(exp_out.size() != 0), 64'd1);
          check_eq("both_pulses", 64'(bus.cmd_done && bus.cmd_err), 64'd0);
          if (exp_out.size() != 0) check_eq("outcome_err", 64'(bus.cmd_err), 64'(exp_out.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [63:0] d, input logic [1:0] c);
    int n = 0;
    while (!bus.cmd_ready && n < 500) begin
      tick();
      n++;
    end
    check_eq("send_ready", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    bus.cmd_cam   = c;
    bus.cmd_valid = 1'b1;
    model_cmd(a, d, c);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_bytes.size() != 0 || exp_out.size() != 0 || bus.i2c_valid) && n < 2000) begin
      tick();
      n++;
    end
    check_eq({tag, "_drain"}, 64'(n < 2000), 64'd1);
    repeat (3) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    logic [7:0]  codes [8];
    int n;
    codes = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h04, 8'h07};
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 8'h00;
    bus.cmd_data  = 64'd0;
    bus.cmd_cam   = 2'd0;
    mdl_comp      = '0;
    mdl_rgb       = '0;

    repeat (3) @(posedge sysClk);
    #1;
    check_eq("rst_valid", 64'(bus.i2c_valid), 64'd0);
    check_eq("rst_byte",  64'(bus.i2c_byte),  64'd0);
    check_eq("rst_first", 64'(bus.i2c_first), 64'd0);
    check_eq("rst_cam",   64'(bus.i2c_cam),   64'd0);
    check_eq("rst_done",  64'(bus.cmd_done),  64'd0);
    check_eq("rst_err",   64'(bus.cmd_err),   64'd0);
    check_eq("rst_comp",  64'(bus.compression), 64'd0);
    check_eq("rst_rgb",   64'(bus.rgb),       64'd0);
    rst = 1'b0;
    tick();
    check_eq("rst_ready", 64'(bus.cmd_ready), 64'd1);

    // Exposure, with first-byte latency
    rdy_mode = 0;
    d = 64'd0;
    d[22:19] = 4'hA;
    d[18:3]  = 16'h1234;
    d[35:23] = 13'h0055;
    send(8'h02, d, 2'd1);
    check_eq("lat_n0", 64'(bus.i2c_valid), 64'd0);
    tick();
    check_eq("lat_n1", 64'(bus.i2c_valid), 64'd0);
    tick();
    check_eq("lat_n2", 64'(bus.i2c_valid), 64'd1);
    check_eq("lat_byte", 64'({bus.i2c_first, bus.i2c_cam, bus.i2c_byte}), 64'({1'b1, 2'd1, 8'h08}));
    wait_idle("expo");

    // Crop with toggling backpressure
    rdy_mode = 1;
    send(8'h05, 64'h0010_0020_0300_0400, 2'd0);
    wait_idle("crop");

    // Config on camera 0
    rdy_mode = 0;
    send(8'h00, 64'h7F, 2'd0);
    wait_idle("config");
    check_eq("cfg_comp0", 64'(bus.compression[1:0]), 64'd3);
    check_eq("cfg_rgb0",  64'(bus.rgb[0]), 64'd1);
    check_eq("cfg_comp1", 64'(bus.compression[3:2]), 64'd0);
    check_eq("cfg_rgb1",  64'(bus.rgb[1]), 64'd0);

    // Bad code and out-of-range camera
    send(8'h07, 64'h3, 2'd0);
    wait_idle("err_code");
    send(8'h00, 64'h3, 2'd3);
    wait_idle("err_cam");
    check_eq("err_comp", 64'(bus.compression), 64'(mdl_comp));
    check_eq("err_rgb",  64'(bus.rgb), 64'(mdl_rgb));

    // FIFO fill behind a stalled command, then drain in order
    rdy_mode = 2;
    send(8'h03, 64'h0000_000F_FFFF_FFF8, 2'd1);
    repeat (3) tick();
    send(8'h05, 64'h1111_2222_3333_4444, 2'd0);
    send(8'h02, 64'h0000_0001_2345_6788, 2'd2);
    send(8'h01, 64'h0000_0000_0000_0035, 2'd2);
    send(8'h06, 64'hAAAA_5555_0F0F_F0F0, 2'd1);
    check_eq("fifo_full", 64'(bus.cmd_ready), 64'd0);
    bus.cmd_addr  = 8'h02;
    bus.cmd_data  = 64'hFFFF;
    bus.cmd_cam   = 2'd0;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check_eq("fifo_still_full", 64'(bus.cmd_ready), 64'd0);
    rdy_mode = 0;
    wait_idle("fifo");

    // Reset during the MSB byte of an exposure, with a command queued behind it
    send(8'h02, d, 2'd1);
    send(8'h05, 64'h0102_0304_0506_0708, 2'd0);
    n = 0;
    while (!(bus.i2c_valid && !bus.i2c_first) && n < 50) begin
      tick();
      n++;
    end
    check_eq("msb_seen", 64'(n < 50), 64'd1);
    rst      = 1'b1;
    rdy_mode = 2;
    tick();
    exp_bytes.delete();
    exp_out.delete();
    mdl_comp = '0;
    mdl_rgb  = '0;
    check_eq("mid_rst_valid", 64'(bus.i2c_valid), 64'd0);
    check_eq("mid_rst_done",  64'(bus.cmd_done), 64'd0);
    check_eq("mid_rst_comp",  64'(bus.compression), 64'd0);
    rst      = 1'b0;
    rdy_mode = 0;
    repeat (10) tick();
    check_eq("post_rst_idle",  64'(bus.i2c_valid), 64'd0);
    check_eq("post_rst_ready", 64'(bus.cmd_ready), 64'd1);
    send(8'h03, d, 2'd2);
    wait_idle("post_rst");

    // Random commands under random backpressure
    rdy_mode = 3;
    for (int i = 0; i < 10; i++) begin
      send(codes[$urandom_range(0, 7)], {$urandom, $urandom}, 2'($urandom_range(0, 3)));
    end
    wait_idle("random");
    check_eq("rand_comp", 64'(bus.compression), 64'(mdl_comp));
    check_eq("rand_rgb",  64'(bus.rgb), 64'(mdl_rgb));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
